// File: rtl/calc_result_display.sv
// Converts an 8-bit calculator result to three BCD digits using shift-add-3.
// Scans them onto a 4-digit common-anode seven-segment display with leading-zero blanking.
module calc_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  result,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state_reg;
  logic [7:0]    shift_reg;
  logic [11:0]   scratch_reg;
  logic [11:0]   scratch_adj;
  logic [11:0]   scratch_next;
  logic [2:0]    iter_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [11:0]   bcd_reg;
  logic [CW-1:0] scan_cnt_reg;
  logic [1:0]    digit_idx_reg;
  logic [3:0]    digit_val;
  logic          digit_blank;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                                      scratch_reg[gi*4 +: 4] + 4'd3 :
                                      scratch_reg[gi*4 +: 4];
    end
  endgenerate

  assign scratch_next = {scratch_adj[10:0], shift_reg[7]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= 8'd0;
      scratch_reg <= 12'd0;
      iter_reg    <= 3'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      bcd_reg     <= 12'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            shift_reg   <= result;
            scratch_reg <= 12'd0;
            iter_reg    <= 3'd0;
            busy_reg    <= 1'b1;
            state_reg   <= CONV;
          end
        end
        CONV: begin
          scratch_reg <= scratch_next;
          shift_reg   <= {shift_reg[6:0], 1'b0};
          iter_reg    <= iter_reg + 3'd1;
          // Eighth iteration: publish the finished digits in the same edge.
          if (iter_reg == 3'd7) begin
            bcd_reg   <= scratch_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= 2'd0;
    end else if (scan_cnt_reg == CW'(REFRESH_DIV - 1)) begin
      scan_cnt_reg  <= '0;
      digit_idx_reg <= digit_idx_reg + 2'd1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    digit_val   = 4'd0;
    digit_blank = 1'b1;
    case (digit_idx_reg)
      2'd0: begin
        digit_val   = bcd_reg[3:0];
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit_val   = bcd_reg[7:4];
        digit_blank = (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
      end
      2'd2: begin
        digit_val   = bcd_reg[11:8];
        digit_blank = (bcd_reg[11:8] == 4'd0);
      end
      default: digit_blank = 1'b1;
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    if (!digit_blank) begin
      case (digit_val)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an[gi] = (digit_idx_reg != 2'(gi));
    end
  endgenerate

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display: expected BCD values are queued at each
// accepted load and compared when done pulses; scan/segment behaviour is checked directly.
module tb_calc_result_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  result;
  logic        load;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  logic [6:0]  seg_tab[10];

  calc_result_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .load(load),
    .busy(busy), .done(done), .bcd(bcd), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; busy/done exclusivity checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("busy_done_excl", {31'd0, busy & done}, 32'd0);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=done expected=no_pending_result", tag);
    end else begin
      check(tag, {20'd0, bcd}, {20'd0, exp_q.pop_front()});
    end
    $display("done: %s bcd=%03h", tag, bcd);
  endtask

  task automatic run_conv(input int v, input string tag);
    load = 1'b1;
    result = 8'(v);
    tick();
    exp_q.push_back(to_bcd(v));
    load = 1'b0;
    check({tag, "_busy_k"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
      check({tag, "_done_early"}, {31'd0, done}, 32'd0);
    end
    tick();
    check({tag, "_done_k8"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_k8"}, {31'd0, busy}, 32'd0);
    pop_check({tag, "_bcd"});
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic wait_an(input logic [3:0] pat);
    int n = 0;
    while (an !== pat && n < 20) begin
      tick();
      n++;
    end
    check("scan_sync", {28'd0, an}, {28'd0, pat});
  endtask

  task automatic seg_at(input int idx, input logic [6:0] exp, input string tag);
    logic [3:0] pat;
    pat = ~(4'b0001 << idx);
    wait_an(pat);
    check(tag, {25'd0, seg}, {25'd0, exp});
    $display("digit %0d: an=%b seg=%b", idx, an, seg);
  endtask

  initial begin
    int ndone, nacc, last, cyc;
    logic prev_busy;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    rst_n = 1'b0;
    load = 1'b0;
    result = 8'd0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {20'd0, bcd}, 32'd0);
    check("rst_an", {28'd0, an}, 32'b1110);
    check("rst_seg", {25'd0, seg}, {25'd0, seg_tab[0]});
    check("rst_dp", {31'd0, dp}, 32'd1);
    rst_n = 1'b1;
    tick();

    run_conv(255, "ff");

    // Zero result: full refresh pattern.
    run_conv(0, "zero");
    wait_an(4'b0111);
    wait_an(4'b1110);
    for (int i = 0; i < 16; i++) begin
      check("zero_an", {28'd0, an}, {28'd0, ~(4'b0001 << (i / 4))});
      check("zero_seg", {25'd0, seg}, (i / 4 == 0) ? {25'd0, seg_tab[0]} : 32'h7f);
      $display("scan %0d: an=%b seg=%b", i, an, seg);
      tick();
    end

    run_conv(105, "d105");
    seg_at(0, seg_tab[5], "d105_ones");
    seg_at(1, seg_tab[0], "d105_tens");
    seg_at(2, seg_tab[1], "d105_hund");
    seg_at(3, 7'b1111111, "d105_d3");

    run_conv(7, "d7");
    seg_at(0, seg_tab[7], "d7_ones");
    seg_at(1, 7'b1111111, "d7_tens_blank");
    seg_at(2, 7'b1111111, "d7_hund_blank");

    // A load during CONV must be ignored.
    load = 1'b1;
    result = 8'd200;
    tick();
    exp_q.push_back(to_bcd(200));
    load = 1'b0;
    tick();
    tick();
    load = 1'b1;
    result = 8'd99;
    tick();
    load = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) begin
        ndone++;
        pop_check("ign_bcd");
      end
    end
    check("ign_done_count", ndone, 1);

    // Reset mid-conversion aborts it.
    load = 1'b1;
    result = 8'd128;
    tick();
    exp_q.push_back(to_bcd(128));
    load = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_bcd", {20'd0, bcd}, 32'd0);
    check("abort_an", {28'd0, an}, 32'b1110);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_conv(128, "d128");

    // Back-to-back with load held high.
    load = 1'b1;
    result = 8'd0;
    ndone = 0;
    nacc = 0;
    last = 0;
    cyc = 0;
    prev_busy = busy;
    while (ndone < 256 && cyc < 3000) begin
      tick();
      cyc++;
      if (busy && !prev_busy) begin
        exp_q.push_back(to_bcd(nacc));
        if (nacc > 0) check("b2b_accept_gap", cyc - last, 9);
        last = cyc;
        nacc++;
        if (nacc == 256) load = 1'b0;
        else result = 8'(nacc);
      end
      if (done) begin
        pop_check("b2b_bcd");
        ndone++;
      end
      prev_busy = busy;
    end
    check("b2b_done_count", ndone, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
